// File: rtl/count_source_pkg.sv
// Shared definitions for the count source: FSM state encoding and prescaler width.
package count_source_pkg;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned PRESC_W = 32;

endpackage

// File: rtl/count_source_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability-count debouncer and
// a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic PRESS
);

    localparam int unsigned CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] stab_q, stab_d;

    // Level flips on the edge where the stability count would reach DB_CYCLES.
    always_comb begin
        stab_d  = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (stab_q == STAB_LAST) begin
                level_d = ~level_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            stab_q       <= '0;
        end else begin
            sync1_q      <= BTN;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            stab_q       <= stab_d;
        end
    end

    assign PRESS = level_q & ~level_prev_q;

endmodule

// File: rtl/count_source.sv
// Run/stop controlled up counter (mod MOD1) and down counter (mod MOD2)
// advanced by a prescaled tick, with wrap pulses and a synchronous clear.
module count_source
    import count_source_pkg::*;
#(
    parameter int unsigned DIV       = 4,
    parameter int unsigned MOD1      = 10,
    parameter int unsigned MOD2      = 16,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    input  logic       CLR,
    output logic [3:0] CNT1,
    output logic [3:0] CNT2,
    output logic       CARRY1,
    output logic       BORROW2,
    output logic       RUNNING
);

    localparam logic [3:0]         CNT1_MAX  = 4'(MOD1 - 1);
    localparam logic [3:0]         CNT2_MAX  = 4'(MOD2 - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

    logic               press;
    logic               tick;
    state_t             state_q, state_d;
    logic               running_q;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         cnt1_q, cnt1_d;
    logic [3:0]         cnt2_q, cnt2_d;
    logic               carry_q, carry_d;
    logic               borrow_q, borrow_d;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN),
        .PRESS (press)
    );

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d = state_q;
        if (press) begin
            state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end
    end

    // CLR is applied last so it overrides a coincident tick; a press still toggles state.
    always_comb begin
        presc_d  = presc_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            if (cnt1_q == CNT1_MAX) begin
                cnt1_d  = '0;
                carry_d = 1'b1;
            end else begin
                cnt1_d = cnt1_q + 4'd1;
            end
            if (cnt2_q == 4'd0) begin
                cnt2_d   = CNT2_MAX;
                borrow_d = 1'b1;
            end else begin
                cnt2_d = cnt2_q - 4'd1;
            end
        end
        if (press) begin
            presc_d = '0;
        end
        if (CLR) begin
            presc_d  = '0;
            cnt1_d   = '0;
            cnt2_d   = CNT2_MAX;
            carry_d  = 1'b0;
            borrow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_STOP;
            running_q <= 1'b0;
            presc_q   <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= CNT2_MAX;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            presc_q   <= presc_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            carry_q   <= carry_d;
            borrow_q  <= borrow_d;
        end
    end

    assign CNT1    = cnt1_q;
    assign CNT2    = cnt2_q;
    assign CARRY1  = carry_q;
    assign BORROW2 = borrow_q;
    assign RUNNING = running_q;

endmodule

// File: tb/tb_count_source.sv
// Directed self-checking bench for count_source with DIV=4, MOD1=10, MOD2=16, DB_CYCLES=4.
module tb_count_source;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] CNT1, CNT2;
    logic       CARRY1, BORROW2, RUNNING;

    int n_pass  = 0;
    int n_total = 0;

    count_source #(
        .DIV       (4),
        .MOD1      (10),
        .MOD2      (16),
        .DB_CYCLES (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BTN     (BTN),
        .CLR     (CLR),
        .CNT1    (CNT1),
        .CNT2    (CNT2),
        .CARRY1  (CARRY1),
        .BORROW2 (BORROW2),
        .RUNNING (RUNNING)
    );

    always #5 CLK = ~CLK;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        n_total++; if (CNT1 !== 4'd0) $display("FAIL reset_cnt1 got %0d want 0", CNT1); else n_pass++;
        n_total++; if (CNT2 !== 4'd15) $display("FAIL reset_cnt2 got %0d want 15", CNT2); else n_pass++;
        n_total++; if (CARRY1 !== 1'b0) $display("FAIL reset_carry got %b want 0", CARRY1); else n_pass++;
        n_total++; if (BORROW2 !== 1'b0) $display("FAIL reset_borrow got %b want 0", BORROW2); else n_pass++;
        n_total++; if (RUNNING !== 1'b0) $display("FAIL reset_running got %b want 0", RUNNING); else n_pass++;
    endtask

    task automatic test_debounce_glitch();
        BTN = 1'b1;
        repeat (2) @(negedge CLK);
        BTN = 1'b0;
        repeat (12) @(negedge CLK);
        n_total++; if (RUNNING !== 1'b0) $display("FAIL glitch_running got %b want 0", RUNNING); else n_pass++;
        n_total++; if (CNT1 !== 4'd0) $display("FAIL glitch_cnt1 got %0d want 0", CNT1); else n_pass++;
    endtask

    task automatic test_press_timing();
        BTN = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 6) begin
                n_total++; if (RUNNING !== 1'b0) $display("FAIL press_edge6 got %b want 0", RUNNING); else n_pass++;
            end
            if (k == 7) begin
                n_total++; if (RUNNING !== 1'b1) $display("FAIL press_edge7 got %b want 1", RUNNING); else n_pass++;
            end
        end
        BTN = 1'b0;
    endtask

    // Tick n lands on edge 4n after RUNNING rose; 79 edges reach CNT1=9 before tick 20.
    task automatic test_run_and_borrow();
        int ticks;
        logic [3:0] e1, e2;
        logic ec, eb;
        for (int c = 1; c <= 79; c++) begin
            @(negedge CLK);
            ticks = c / 4;
            e1 = 4'(ticks % 10);
            e2 = 4'(15 - ticks);
            ec = (c % 4 == 0) && (ticks % 10 == 0) && (ticks != 0);
            eb = (c % 4 == 0) && (ticks % 16 == 0) && (ticks != 0);
            n_total++; if (CNT1 !== e1) $display("FAIL run_cnt1 c=%0d got %0d want %0d", c, CNT1, e1); else n_pass++;
            n_total++; if (CNT2 !== e2) $display("FAIL run_cnt2 c=%0d got %0d want %0d", c, CNT2, e2); else n_pass++;
            n_total++; if (CARRY1 !== ec) $display("FAIL run_carry c=%0d got %b want %b", c, CARRY1, ec); else n_pass++;
            n_total++; if (BORROW2 !== eb) $display("FAIL run_borrow c=%0d got %b want %b", c, BORROW2, eb); else n_pass++;
        end
        n_total++; if (RUNNING !== 1'b1) $display("FAIL release_running got %b want 1", RUNNING); else n_pass++;
    endtask

    task automatic test_clr_on_tick();
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        n_total++; if (CNT1 !== 4'd0) $display("FAIL clr_cnt1 got %0d want 0", CNT1); else n_pass++;
        n_total++; if (CNT2 !== 4'd15) $display("FAIL clr_cnt2 got %0d want 15", CNT2); else n_pass++;
        n_total++; if (CARRY1 !== 1'b0) $display("FAIL clr_carry got %b want 0", CARRY1); else n_pass++;
        n_total++; if (RUNNING !== 1'b1) $display("FAIL clr_running got %b want 1", RUNNING); else n_pass++;
    endtask

    task automatic test_stop_resume();
        int k_stop = 99;
        int k_run  = 99;
        BTN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (RUNNING === 1'b0) begin
                k_stop = k;
                break;
            end
        end
        BTN = 1'b0;
        n_total++; if (k_stop !== 7) $display("FAIL stop_latency got %0d want 7", k_stop); else n_pass++;
        n_total++; if (CNT1 !== 4'd1) $display("FAIL stop_cnt1 got %0d want 1", CNT1); else n_pass++;
        n_total++; if (CNT2 !== 4'd14) $display("FAIL stop_cnt2 got %0d want 14", CNT2); else n_pass++;
        repeat (20) @(negedge CLK);
        n_total++; if (CNT1 !== 4'd1) $display("FAIL hold_cnt1 got %0d want 1", CNT1); else n_pass++;
        n_total++; if (CNT2 !== 4'd14) $display("FAIL hold_cnt2 got %0d want 14", CNT2); else n_pass++;
        n_total++; if (RUNNING !== 1'b0) $display("FAIL hold_running got %b want 0", RUNNING); else n_pass++;
        BTN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (RUNNING === 1'b1) begin
                k_run = k;
                break;
            end
        end
        BTN = 1'b0;
        n_total++; if (k_run !== 7) $display("FAIL resume_latency got %0d want 7", k_run); else n_pass++;
        for (int j = 1; j <= 4; j++) begin
            @(negedge CLK);
            if (j == 3) begin
                n_total++; if (CNT1 !== 4'd1) $display("FAIL resume_pre_cnt1 got %0d want 1", CNT1); else n_pass++;
            end
            if (j == 4) begin
                n_total++; if (CNT1 !== 4'd2) $display("FAIL resume_cnt1 got %0d want 2", CNT1); else n_pass++;
                n_total++; if (CNT2 !== 4'd13) $display("FAIL resume_cnt2 got %0d want 13", CNT2); else n_pass++;
            end
        end
    endtask

    task automatic test_rst_mid();
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_total++; if (CNT1 !== 4'd0) $display("FAIL rstmid_cnt1 got %0d want 0", CNT1); else n_pass++;
        n_total++; if (CNT2 !== 4'd15) $display("FAIL rstmid_cnt2 got %0d want 15", CNT2); else n_pass++;
        n_total++; if (RUNNING !== 1'b0) $display("FAIL rstmid_running got %b want 0", RUNNING); else n_pass++;
        repeat (8) @(negedge CLK);
        n_total++; if (CNT1 !== 4'd0) $display("FAIL rstmid_hold_cnt1 got %0d want 0", CNT1); else n_pass++;
        n_total++; if (CNT2 !== 4'd15) $display("FAIL rstmid_hold_cnt2 got %0d want 15", CNT2); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_debounce_glitch();
        test_press_timing();
        test_run_and_borrow();
        test_clr_on_tick();
        test_stop_resume();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
